fetch_refill_controller: RTL
============================

// Module: fetch_refill_controller
// PURPOSE
//  Sequences the instruction-fetch path on an I-cache miss. It drives the PC register's
//  update enable (hit), so the PC advances only on a cache hit. On a miss it stalls
//  the PC and burst-refills one cache line from memory, word by word, with a req/ack
//  handshake. It then marks the line valid and resumes fetch.
//  Sits between the PC register, the I-cache tag/data arrays and the memory interface.
// PARAMETERS
//  BLOCK_WORDS  4   words per cache line; power of two, 2..16
//  OFF_BITS     2   byte-offset bits per word (32-bit words)
// PORTS
//  clock        in   1   system clock; state updates on posedge
//  reset        in   1   asynchronous, active-high reset
//  pc           in   32  current PC (PC register output)
//  tag_hit      in   1   I-cache lookup result for pc (combinational, same cycle)
//  mem_ack      in   1   memory returns one word on mem_rdata this cycle
//  mem_rdata    in   32  refill data word
//  pc_en        out  1   PC update enable; connects to the PC register hit input
//  mem_req      out  1   refill request, held high for the whole burst
//  mem_addr     out  32  word address currently requested
//  cache_we     out  1   write strobe into the I-cache data array
//  cache_waddr  out  32  address of the word being written
//  cache_wdata  out  32  data being written (= mem_rdata)
//  line_valid   out  1   one-cycle pulse: set valid bit/tag for the refilled line
//  refill_busy  out  1   high while state != IDLE
// BEHAVIOUR
//  - States: IDLE, FILL, DONE. Reset (async) -> IDLE, word counter cnt=0, base=0.
//  - Reset values: pc_en=0, mem_req=0, mem_addr=0, cache_we=0, cache_waddr=0,
//    line_valid=0, refill_busy=0.
//  - pc_en = (state==IDLE) & tag_hit & ~reset. Combinational, so the PC
//    (negedge-sampled) sees a stable value mid-cycle.
//  - IDLE: on tag_hit=0 at posedge -> FILL; latch base = pc with low
//    log2(BLOCK_WORDS)+OFF_BITS bits cleared; cnt=0.
//  - FILL: mem_req=1; mem_addr = base + (cnt<<OFF_BITS).
//    mem_ack may arrive any cycle, including the first FILL cycle.
//    On mem_ack: cache_we=1, cache_waddr=mem_addr, cache_wdata=mem_rdata (all comb);
//    cnt increments at posedge.
//    No ack -> hold all outputs and cnt unchanged (wait states unbounded).
//  - Last word (cnt==BLOCK_WORDS-1 & mem_ack) -> DONE; cnt wraps to 0.
//    mem_req is 0 from DONE on.
//  - DONE: line_valid=1 for exactly one cycle, pc_en=0 -> IDLE.
//    The next cycle re-evaluates tag_hit, which is now 1.
//  - Miss penalty = BLOCK_WORDS ack cycles + 1 (DONE) + 1 (IDLE lookup).
//  - mem_ack outside FILL is ignored: no cache_we, no state change.
//  - pc change during FILL is ignored; base stays frozen until DONE.
//  - reset mid-FILL: immediate return to IDLE, mem_req drops asynchronously,
//    line_valid is never pulsed. The partial line stays invalid.
// CONFIGURATION
//  MISS_STATS_EN defined: adds outputs miss_count[31:0] and stall_cycles[31:0].
//    miss_count +1 on each IDLE->FILL transition.
//    stall_cycles +1 on every cycle with refill_busy=1.
//    Both clear on reset and saturate at 32'hFFFF_FFFF (no wrap).
//  MISS_STATS_EN not defined: neither port nor counter exists; functional behaviour
//    is otherwise identical.
// TESTING
//  1. tag_hit=1 steady, pc=0x40 -> pc_en=1 every cycle; mem_req=0, refill_busy=0.
//  2. pc=0x1C, tag_hit=0, ack every cycle -> mem_addr 0x10,0x14,0x18,0x1C;
//     4 cache_we pulses; line_valid 1 cycle; pc_en low for exactly 6 cycles.
//  3. Same miss, ack after 3 wait cycles per word -> mem_addr/mem_req held during waits;
//     exactly 4 cache_we pulses; cnt never skips.
//  4. Assert reset after 2nd ack -> state IDLE same cycle; mem_req=0; no line_valid;
//     next miss restarts at word 0.
//  5. Spurious mem_ack in IDLE with tag_hit=1 -> no cache_we, pc_en stays 1.
//  6. MISS_STATS_EN defined, 3 misses at zero wait states -> miss_count=3, stall_cycles=15
//     (5 busy cycles each, BLOCK_WORDS=4). Undefined -> design elaborates without the ports.

Source files
------------

// File: rtl/fetch_refill_controller.sv
// I-cache miss refill sequencer: stalls the PC on a miss and burst-refills one line via req/ack.
// Optional MISS_STATS_EN macro adds saturating miss_count_o / stall_cycles_o counters.
module fetch_refill_controller #(
    parameter int unsigned BLOCK_WORDS = 4,
    parameter int unsigned OFF_BITS    = 2
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [31:0] pc_i,
    input  logic        tag_hit_i,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        pc_en_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic        cache_we_o,
    output logic [31:0] cache_waddr_o,
    output logic [31:0] cache_wdata_o,
    output logic        line_valid_o,
`ifdef MISS_STATS_EN
    output logic [31:0] miss_count_o,
    output logic [31:0] stall_cycles_o,
`endif
    output logic        refill_busy_o
);

    localparam int unsigned CNT_W     = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam int unsigned LINE_BITS = CNT_W + OFF_BITS;
    localparam logic [31:0] LINE_MASK = (32'd1 << LINE_BITS) - 32'd1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      base_q, base_d;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        base_d        = base_q;
        pc_en_o       = 1'b0;
        mem_req_o     = 1'b0;
        mem_addr_o    = '0;
        cache_we_o    = 1'b0;
        cache_waddr_o = '0;
        line_valid_o  = 1'b0;
        refill_busy_o = (state_q != ST_IDLE);
        cache_wdata_o = mem_rdata_i;

        case (state_q)
            ST_IDLE: begin
                // reset gates pc_en directly so the PC never advances while reset is asserted
                pc_en_o = tag_hit_i & ~reset_i;
                if (!tag_hit_i) begin
                    state_d = ST_FILL;
                    base_d  = pc_i & ~LINE_MASK;
                    cnt_d   = '0;
                end
            end
            ST_FILL: begin
                mem_req_o  = 1'b1;
                mem_addr_o = base_q + (32'(cnt_q) << OFF_BITS);
                if (mem_ack_i) begin
                    cache_we_o    = 1'b1;
                    cache_waddr_o = mem_addr_o;
                    if (cnt_q == LAST_WORD) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                line_valid_o = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef MISS_STATS_EN
    logic [31:0] miss_count_q, miss_count_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            miss_count_q   <= '0;
            stall_cycles_q <= '0;
        end else begin
            miss_count_q   <= miss_count_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    always_comb begin
        miss_count_d   = miss_count_q;
        stall_cycles_d = stall_cycles_q;
        if ((state_q == ST_IDLE) && !tag_hit_i && (miss_count_q != '1))
            miss_count_d = miss_count_q + 32'd1;
        if (refill_busy_o && (stall_cycles_q != '1))
            stall_cycles_d = stall_cycles_q + 32'd1;
    end

    assign miss_count_o   = miss_count_q;
    assign stall_cycles_o = stall_cycles_q;
`endif

endmodule
